// File: rtl/mem_sram_ctrl.sv
// Data-memory responder: each 32-bit load/store from the MEM stage becomes two
// 16-bit SRAM accesses, with ready held low while the access is in flight.
module mem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_read;
    logic [16:0]   word;
    logic [15:0]   wdata_hi;
    logic [31:0]   offset;
    logic          req;
    logic          unused_offset_bits;

    assign offset = address - BASE_ADDR;
    assign req    = rd_en | wr_en;

    // Only bits [18:2] of the rebased address select an SRAM word.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    always_comb begin
        case (state)
            IDLE:    ready = ~req;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // SRAM pins are registered together with the state transition so they
    // change only on phase boundaries and drop asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_read     <= 1'b0;
            word        <= '0;
            wdata_hi    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_read   <= rd_en;
                        word      <= offset[18:2];
                        wdata_hi  <= write_data[31:16];
                        cnt       <= '0;
                        state     <= LOW;
                        sram_addr <= {offset[18:2], 1'b0};
                        if (rd_en) begin
                            sram_oe_n  <= 1'b0;
                            sram_we_n  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                        end else begin
                            sram_oe_n   <= 1'b1;
                            sram_we_n   <= 1'b0;
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= write_data[15:0];
                        end
                    end
                end
                LOW: begin
                    if (cnt == CNT_LAST) begin
                        if (op_read) begin
                            read_data[15:0] <= sram_dq_in;
                        end else begin
                            sram_dq_out <= wdata_hi;
                        end
                        cnt       <= '0;
                        state     <= HIGH;
                        sram_addr <= {word, 1'b1};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (cnt == CNT_LAST) begin
                        if (op_read) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                        cnt        <= '0;
                        state      <= DONE;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // DONE never starts an access, even with the request still held.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: directed vector table, reset and
// back-to-back sequences, then random accesses against a word-level memory model.
module tb_mem_sram_ctrl;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int          W    = 2;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;

    mem_sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SRAM pad model with a backdoor port used to preload contents.
    bit   [15:0] sram_mem [0:262143];
    logic        poke_en;
    logic [17:0] poke_addr;
    logic [15:0] poke_data;

    assign sram_dq_in = sram_mem[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq_out;
        end else if (poke_en) begin
            sram_mem[poke_addr] <= poke_data;
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_read;
    logic [31:0] ref_words [int];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [17:0] exp_base;
        logic [31:0] exp_rd;
        logic        b2b;
    } vec_t;

    vec_t vecs [9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % 32'd131072);
    endfunction

    function automatic logic [31:0] ref_read(input int w);
        if (ref_words.exists(w)) return ref_words[w];
        return 32'd0;
    endfunction

    task automatic poke(input logic [17:0] a, input logic [15:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1;
        poke_en   = 1'b0;
    endtask

    task automatic go_idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_output("idle_ready", 32'(ready), 32'd1);
    endtask

    // Starts at #1 after an edge in IDLE; returns #1 into cycle 2W+2 with the request still held.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [17:0] exp_base,
                                  input logic [31:0] exp_rd);
        logic is_read;
        logic hi;
        is_read    = rd;
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = wd;
        @(negedge clk);
        check_output("ready_cycle0", 32'(ready), 32'd0);
        for (int k = 1; k <= 2 * W + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 2 * W) begin
                hi = (k > W);
                check_output("sram_addr", 32'(sram_addr), 32'(exp_base | 18'(hi)));
                check_output("ready_busy", 32'(ready), 32'd0);
                check_output("we_n_phase", 32'(sram_we_n), is_read ? 32'd1 : 32'd0);
                check_output("oe_n_phase", 32'(sram_oe_n), is_read ? 32'd0 : 32'd1);
                check_output("dq_oe_phase", 32'(sram_dq_oe), is_read ? 32'd0 : 32'd1);
                if (!is_read) begin
                    check_output("dq_out", 32'(sram_dq_out), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
                end
            end else begin
                check_output("ready_done", 32'(ready), 32'd1);
                check_output("read_data", read_data, is_read ? exp_rd : last_read);
                check_output("we_n_done", 32'(sram_we_n), 32'd1);
                check_output("oe_n_done", 32'(sram_oe_n), 32'd1);
                check_output("dq_oe_done", 32'(sram_dq_oe), 32'd0);
            end
        end
        if (is_read) last_read = exp_rd;
        @(posedge clk);
        #1;
        check_output("ready_after_done", 32'(ready), 32'd0);
        check_output("we_n_after_done", 32'(sram_we_n), 32'd1);
        check_output("oe_n_after_done", 32'(sram_oe_n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 18'h00000, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,         18'h00004, 32'hABCD_1234, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         18'h00000, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0404, 32'h5555_6666, 18'h00002, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 18'h3FFFE, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_03FE, 32'h0,         18'h3FFFE, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0008_0400, 32'h1122_3344, 18'h00000, 32'h0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0403, 32'h0,         18'h00000, 32'h1122_3344, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,         18'h00002, 32'h0, 1'b0};

        rst_n      = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        poke_en    = 1'b0;
        poke_addr  = '0;
        poke_data  = '0;
        last_read  = 32'd0;

        #12;
        check_output("rst_ready", 32'(ready), 32'd1);
        check_output("rst_we_n", 32'(sram_we_n), 32'd1);
        check_output("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_output("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check_output("rst_read_data", read_data, 32'd0);
        check_output("rst_sram_addr", 32'(sram_addr), 32'd0);
        check_output("rst_dq_out", 32'(sram_dq_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        poke(18'd4, 16'h1234);
        poke(18'd5, 16'hABCD);
        ref_words[2] = 32'hABCD_1234;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                           vecs[i].exp_base, vecs[i].exp_rd);
            if (vecs[i].wr && !vecs[i].rd) ref_words[word_of(vecs[i].addr)] = vecs[i].wd;
            if (!vecs[i].b2b) go_idle();
        end

        // Reset in the middle of the HIGH half of a store.
        rd_en      = 1'b0;
        wr_en      = 1'b1;
        address    = 32'h0000_1400;
        write_data = 32'h0BAD_CAFE;
        repeat (3) @(posedge clk);
        #2;
        check_output("we_n_before_rst", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check_output("we_n_async_rst", 32'(sram_we_n), 32'd1);
        check_output("dq_oe_async_rst", 32'(sram_dq_oe), 32'd0);
        check_output("oe_n_async_rst", 32'(sram_oe_n), 32'd1);
        check_output("ready_rst_req", 32'(ready), 32'd0);
        wr_en = 1'b0;
        #1;
        check_output("ready_rst_noreq", 32'(ready), 32'd1);
        check_output("read_data_rst", read_data, 32'd0);
        last_read = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("ready_after_rst", 32'(ready), 32'd1);
        check_output("we_n_after_rst", 32'(sram_we_n), 32'd1);

        for (int i = 0; i < 40; i++) begin
            int          op;
            int          w;
            logic [31:0] a;
            logic [31:0] d;
            op = int'($urandom_range(0, 2));
            a  = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            d  = $urandom;
            w  = word_of(a);
            apply_stimulus(op != 1, op != 0, a, d, 18'(w * 2), ref_read(w));
            if (op == 1) ref_words[w] = d;
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
